// File: rtl/stack_arbiter.sv
// Round-robin arbiter/sequencer sharing one LIFO stack between two clients plus a clear requester.
// Grant in IDLE at T, stack command at T+1, ack/clr_done pulse at T+3; clients hold req until ack.
module stack_arbiter #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          op0,
  input  logic          op1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          clr_req,
  output logic          ack0,
  output logic          ack1,
  output logic          clr_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic [LW-1:0] level,
  output logic [1:0]    stk_cmd,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  input  logic          stk_full,
  input  logic          stk_empty,
  input  logic          stk_error
);

  localparam logic [1:0]    CMD_NOP  = 2'b00;
  localparam logic [1:0]    CMD_CLR  = 2'b01;
  localparam logic [1:0]    CMD_PUSH = 2'b10;
  localparam logic [1:0]    CMD_POP  = 2'b11;
  localparam logic [LW-1:0] LVL_MAX  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    cmd_q, cmd_d;
  logic [DW-1:0] din_q, din_d;
  logic          rr_q, rr_d;
  logic          win_q, win_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          clr_done_q, clr_done_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [LW-1:0] level_q, level_d;

  logic gnt_clr, gnt0, gnt1;

  // rr_q holds the last winner; on contention the other client is granted.
  always_comb begin
    gnt_clr = (state_q == S_IDLE) && clr_req;
    gnt1    = (state_q == S_IDLE) && !clr_req && req1 && (!req0 || !rr_q);
    gnt0    = (state_q == S_IDLE) && !clr_req && req0 && (!req1 || rr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_IDLE;
      S_IDLE:  if (gnt_clr || gnt0 || gnt1) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    stk_cmd = CMD_NOP;
    if (rst || (state_q == S_INIT)) begin
      stk_cmd = CMD_CLR;
    end else if (state_q == S_ISSUE) begin
      stk_cmd = cmd_q;
    end
    busy = (state_q != S_IDLE);
  end

  // Response registers load at the end of WAIT so they are visible during RESP.
  always_comb begin
    cmd_d      = cmd_q;
    din_d      = din_q;
    rr_d       = rr_q;
    win_d      = win_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    clr_done_d = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    level_d    = level_q;

    if (gnt_clr) begin
      cmd_d = CMD_CLR;
    end
    if (gnt0) begin
      cmd_d = op0 ? CMD_POP : CMD_PUSH;
      din_d = wdata0;
      rr_d  = 1'b0;
      win_d = 1'b0;
    end
    if (gnt1) begin
      cmd_d = op1 ? CMD_POP : CMD_PUSH;
      din_d = wdata1;
      rr_d  = 1'b1;
      win_d = 1'b1;
    end

    if (state_q == S_INIT) begin
      level_d = '0;
    end

    if (state_q == S_WAIT) begin
      if (cmd_q == CMD_CLR) begin
        clr_done_d = 1'b1;
        err_d      = 1'b0;
        level_d    = '0;
      end else begin
        ack0_d = !win_q;
        ack1_d = win_q;
        err_d  = stk_error;
        // Successful commands resync occupancy to the stack's own flags.
        if (!stk_error && (cmd_q == CMD_PUSH)) begin
          level_d = (stk_full || (level_q >= LVL_MAX)) ? LVL_MAX : level_q + LVL_ONE;
        end
        if (!stk_error && (cmd_q == CMD_POP)) begin
          rdata_d = stk_dout;
          level_d = (stk_empty || (level_q == '0)) ? '0 : level_q - LVL_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= CMD_NOP;
      din_q      <= '0;
      rr_q       <= 1'b0;
      win_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      clr_done_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      level_q    <= '0;
    end else begin
      cmd_q      <= cmd_d;
      din_q      <= din_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      clr_done_q <= clr_done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      level_q    <= level_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign clr_done = clr_done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign level    = level_q;
  assign stk_din  = din_q;

endmodule
